alu_word_sequencer: RTL



---
 rtl/alu_word_sequencer_if.sv | 33 +++
 rtl/alu_word_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer_if.sv
// Bus between decode/regfile, the word sequencer and the 8-bit ALU.
// The slave modport is the sequencer; the master side is the surrounding datapath and ALU.
interface alu_word_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPSEL_COUNT = 4
);
  logic                      start;
  logic [1:0]                op;
  logic [2*DATA_WIDTH-1:0]   a;
  logic [2*DATA_WIDTH-1:0]   b;
  logic                      busy;
  logic                      done;
  logic [2*DATA_WIDTH-1:0]   result;
  logic [7:0]                sreg;
  logic                      sreg_we;
  logic [7:0]                sreg_wdata;
  logic [OPSEL_COUNT-1:0]    alu_opsel;
  logic [DATA_WIDTH-1:0]     alu_rd;
  logic [DATA_WIDTH-1:0]     alu_rr;
  logic [7:0]                alu_flags_in;
  logic [DATA_WIDTH-1:0]     alu_out;
  logic [7:0]                alu_flags_out;

  modport slave (
    input  start, op, a, b, sreg_we, sreg_wdata, alu_out, alu_flags_out,
    output busy, done, result, sreg, alu_opsel, alu_rd, alu_rr, alu_flags_in
  );

  modport master (
    output start, op, a, b, sreg_we, sreg_wdata, alu_out, alu_flags_out,
    input  busy, done, result, sreg, alu_opsel, alu_rd, alu_rr, alu_flags_in
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// Runs 16-bit ADD/ADC/AND/OR as two byte ops on the 8-bit ALU (low then high),
// chaining carry through the flags and owning the architectural status register.
module alu_word_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_word_sequencer_if.slave  bus
);
  localparam int W = 2 * DATA_WIDTH;

  localparam logic [3:0] OPSEL_NOP = 4'b0000;
  localparam logic [3:0] OPSEL_ADD = 4'b0001;
  localparam logic [3:0] OPSEL_ADC = 4'b0010;
  localparam logic [3:0] OPSEL_AND = 4'b0100;
  localparam logic [3:0] OPSEL_OR  = 4'b1000;
  localparam int         FLAGS_Z   = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                state_q;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [1:0]            op_q;
  logic [7:0]            tmp_flags_q;
  logic                  z_low_q;
  logic [DATA_WIDTH-1:0] res_lo_q;
  logic [W-1:0]          result_q;
  logic [7:0]            sreg_q;
  logic [7:0]            sreg_d;
  logic                  busy_q;
  logic                  done_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.sreg   = sreg_q;

  always_comb begin
    bus.alu_opsel    = OPSEL_NOP;
    bus.alu_rd       = '0;
    bus.alu_rr       = '0;
    bus.alu_flags_in = sreg_q;
    case (state_q)
      S_LOW: begin
        bus.alu_rd = a_q[DATA_WIDTH-1:0];
        bus.alu_rr = b_q[DATA_WIDTH-1:0];
        case (op_q)
          2'b00:   bus.alu_opsel = OPSEL_ADD;
          2'b01:   bus.alu_opsel = OPSEL_ADC;
          2'b10:   bus.alu_opsel = OPSEL_AND;
          default: bus.alu_opsel = OPSEL_OR;
        endcase
      end
      S_HIGH: begin
        bus.alu_rd       = a_q[W-1:DATA_WIDTH];
        bus.alu_rr       = b_q[W-1:DATA_WIDTH];
        bus.alu_flags_in = tmp_flags_q;
        // Both arithmetic ops chain the low-byte carry, so the high byte is always ADC.
        if (op_q[1]) bus.alu_opsel = op_q[0] ? OPSEL_OR : OPSEL_AND;
        else         bus.alu_opsel = OPSEL_ADC;
      end
      default: ;
    endcase
  end

  // Sequencer write at the end of HIGH beats an external write on the same edge.
  always_comb begin
    sreg_d = sreg_q;
    if (state_q == S_HIGH) begin
      sreg_d          = bus.alu_flags_out;
      sreg_d[FLAGS_Z] = bus.alu_flags_out[FLAGS_Z] & z_low_q;
    end else if (bus.sreg_we) begin
      sreg_d = bus.sreg_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tmp_flags_q <= '0;
      z_low_q     <= 1'b0;
      res_lo_q    <= '0;
      result_q    <= '0;
      sreg_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            busy_q  <= 1'b1;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          res_lo_q    <= bus.alu_out;
          tmp_flags_q <= bus.alu_flags_out;
          z_low_q     <= bus.alu_flags_out[FLAGS_Z];
          state_q     <= S_HIGH;
        end
        S_HIGH: begin
          result_q <= {bus.alu_out, res_lo_q};
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
